simd_pipelined_adder: RTL and testbench
=======================================

Name: simd_pipelined_adder

Overview:
- Parametrised, pipelined successor to the fixed 32-bit split adder.
- Adds or subtracts WIDTH-bit operands as independent SIMD lanes of SEG, 2*SEG, 4*SEG bits, or full width.
- Carry advances one SEG-bit segment per clock, so throughput is one operation per cycle with valid/ready flow control on both sides.
- Sits between the operand register file and the result bus in the datapath.

Parameters:
WIDTH, 64, operand/result width; must be a multiple of SEG
SEG, 16, segment width computed per pipeline stage; NSEG = WIDTH/SEG must be a power of 2, >= 1

Ports:
Clk  input  1  clock; all state updates on rising edge
Rst  input  1  asynchronous, active-high reset
A  input  WIDTH  operand A; bit 0 = LSB
B  input  WIDTH  operand B
Ci  input  1  carry-in to lane 0 (add mode only)
Sub  input  1  1 = per-lane A-B, 0 = A+B
LaneMode  input  2  lane size: 0 = SEG, 1 = 2*SEG, 2 = 4*SEG, 3 = WIDTH
InValid  input  1  operands/controls valid
InReady  output  1  block accepts this cycle
S  output  WIDTH  result
Co  output  NSEG  carry-out per segment; nonzero only at lane-top segments
OutValid  output  1  S/Co valid
OutReady  input  1  consumer accepts

Behaviour:
- Reset (asynchronous, active-high): all stage valid bits, OutValid, S and Co clear to 0 immediately. No stale result may emerge after release. InReady = 1 in the first cycle after reset.
- Segments: segment k = bits [k*SEG +: SEG].
- Lane size:
  - L = SEG << LaneMode for LaneMode 0..2, clamped to WIDTH when it exceeds WIDTH.
  - L = WIDTH for LaneMode 3.
  - LS = L/SEG segments per lane.
- Carry chain: carry from segment k into k+1 is blocked (forced to lane carry-in) when (k+1) mod LS == 0.
- Lane carry-in:
  - Add: lane 0 gets Ci; all other lanes get 0.
  - Sub: B is inverted and every lane gets carry-in 1; Ci is ignored.
- Co[k]:
  - Equals the raw carry out of segment k when k is a lane-top segment ((k+1) mod LS == 0); otherwise 0.
  - In Sub mode, Co=1 means no borrow.
- Pipeline:
  - NSEG stages. Stage j (1..NSEG) computes segment j-1 from the operand bits and the carry registered in stage j-1.
  - Completed low segments and pending high operand bits travel with the transaction, together with Sub, LaneMode and Ci.
- Latency: a transaction accepted at edge t (InValid & InReady) appears with OutValid = 1 after edge t+NSEG.
- Handshake:
  - stall = OutValid & ~OutReady; InReady = ~stall (combinational).
  - When stall = 1, every stage holds, and S, Co and OutValid remain stable.
  - When stall = 0, all stages shift one place; empty slots (bubbles) propagate as valid = 0.
  - Input fields are sampled only on acceptance. A/B may change freely while InReady = 0.
- Simultaneous output pop and input accept in one cycle is legal and sustains full throughput.
- Ordering: results leave strictly in acceptance order; no drops, no duplicates.
- LaneMode and Sub are captured per transaction; a mode change between back-to-back transactions needs no bubble.
- Overflow: lane results wrap modulo 2^L; no saturation or overflow flag.
- Asserting Rst mid-flight discards all in-flight transactions.

Test Plan:
- Full-width carry, WIDTH=64, SEG=16, LaneMode=3, Sub=0, A=0xFFFF_FFFF_FFFF_FFFF, B=1, Ci=0 -> after 4 cycles S=0, Co=4'b1000, OutValid=1.
- 16-bit lanes, LaneMode=0, A=0xFFFF_FFFF_FFFF_FFFF, B=0x0001_0001_0001_0001 -> S=0, Co=4'b1111. Same with Ci=1, A=B=0 -> S=0x0000_0000_0000_0001, Co=0.
- 32-bit subtract, LaneMode=1, Sub=1, A=0x00000003_00000005, B=0x00000005_00000003 -> S=0xFFFFFFFE_00000002, Co=4'b0010.
- Backpressure:
  - Stimulus: 8 back-to-back transactions with InValid=1; OutReady=0 from the first OutValid for 10 cycles, then OutReady=1.
  - Response: S, Co and OutValid stay stable and InReady=0 while stalled; after release all 8 results emerge in order on consecutive cycles.
- Reset mid-flight: Rst pulsed between clock edges with 3 transactions in flight -> OutValid=0 and S=0 immediately; after release no result appears until a new accept + 4 cycles.
- Mixed modes back-to-back: LaneMode 0, 1, 2, 3 on consecutive cycles with identical A/B -> each result matches a per-mode reference model, with no bubble between outputs.

Source files
------------

// File: rtl/simd_pipelined_adder_if.sv
// simd_pipelined_adder_if: operand/result handshake bundle.
// master drives A/B/Ci/Sub/LaneMode/InValid/OutReady; slave drives InReady/S/Co/OutValid.
interface simd_pipelined_adder_if #(
  parameter int WIDTH = 64,
  parameter int SEG   = 16
);
  localparam int NSEG = WIDTH / SEG;

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Ci;
  logic             Sub;
  logic [1:0]       LaneMode;
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] S;
  logic [NSEG-1:0]  Co;
  logic             OutValid;
  logic             OutReady;

  modport master (
    output A, B, Ci, Sub, LaneMode, InValid, OutReady,
    input  InReady, S, Co, OutValid
  );

  modport slave (
    input  A, B, Ci, Sub, LaneMode, InValid, OutReady,
    output InReady, S, Co, OutValid
  );
endinterface

// File: rtl/simd_pipelined_adder.sv
// simd_pipelined_adder: SIMD add/sub, carry advances one SEG segment per stage.
// Ports: Clk, Rst (async high), io (slave: operands in, S/Co out, valid/ready both sides).
module simd_pipelined_adder #(
  parameter int WIDTH = 64,
  parameter int SEG   = 16
) (
  input logic Clk,
  input logic Rst,
  simd_pipelined_adder_if.slave io
);
  localparam int NSEG = WIDTH / SEG;
  localparam int LW   = $clog2(NSEG) + 1;

  // stage 0 is the input register; stage j computes segment j-1
  logic             v_q   [NSEG+1];
  logic [WIDTH-1:0] a_q   [NSEG+1];
  logic [WIDTH-1:0] b_q   [NSEG+1];
  logic [WIDTH-1:0] s_q   [NSEG+1];
  logic [NSEG-1:0]  co_q  [NSEG+1];
  logic             cy_q  [NSEG+1];
  logic             ci_q  [NSEG+1];
  logic             sub_q [NSEG+1];
  logic [LW-1:0]    ls_q  [NSEG+1];

  logic [WIDTH-1:0] s_d  [1:NSEG];
  logic [NSEG-1:0]  co_d [1:NSEG];
  logic             cy_d [1:NSEG];

  logic stall;

  // segments per lane, clamped to the full word
  function automatic logic [LW-1:0] lane_segs(
    input logic [1:0] m
  );
    int n;
    unique case (m)
      2'd0:    n = 1;
      2'd1:    n = 2;
      2'd2:    n = 4;
      default: n = NSEG;
    endcase
    if (n > NSEG) n = NSEG;
    return LW'(n);
  endfunction

  assign stall       = v_q[NSEG] & ~io.OutReady;
  assign io.InReady  = ~stall;
  assign io.OutValid = v_q[NSEG];
  assign io.S        = s_q[NSEG];
  assign io.Co       = co_q[NSEG];

  always_comb begin
    int            k;
    logic [LW-1:0] msk;
    logic [LW-1:0] kk;
    logic [LW-1:0] kp;
    logic          cin;
    logic [SEG:0]  sum;
    k   = 0;
    msk = '0;
    kk  = '0;
    kp  = '0;
    cin = 1'b0;
    sum = '0;
    for (int j = 1; j <= NSEG; j++) begin
      k   = j - 1;
      msk = ls_q[j-1] - LW'(1);
      kk  = LW'(k);
      kp  = LW'(k + 1);
      // lane bottom: sub forces 1, add feeds Ci to lane 0 only
      if ((kk & msk) == '0)
        cin = (k == 0) ? (sub_q[j-1] | ci_q[j-1])
                       : sub_q[j-1];
      else
        cin = cy_q[j-1];
      sum = {1'b0, a_q[j-1][k*SEG +: SEG]}
          + {1'b0, b_q[j-1][k*SEG +: SEG]}
          + {{SEG{1'b0}}, cin};
      s_d[j] = s_q[j-1];
      s_d[j][k*SEG +: SEG] = sum[SEG-1:0];
      co_d[j]    = co_q[j-1];
      co_d[j][k] = ((kp & msk) == '0) & sum[SEG];
      cy_d[j]    = sum[SEG];
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int j = 0; j <= NSEG; j++) begin
        v_q[j]   <= 1'b0;
        a_q[j]   <= '0;
        b_q[j]   <= '0;
        s_q[j]   <= '0;
        co_q[j]  <= '0;
        cy_q[j]  <= 1'b0;
        ci_q[j]  <= 1'b0;
        sub_q[j] <= 1'b0;
        ls_q[j]  <= '0;
      end
    end else if (!stall) begin
      v_q[0] <= io.InValid;
      if (io.InValid) begin
        a_q[0]   <= io.A;
        // subtract as A + ~B + 1
        b_q[0]   <= io.Sub ? ~io.B : io.B;
        s_q[0]   <= '0;
        co_q[0]  <= '0;
        cy_q[0]  <= 1'b0;
        ci_q[0]  <= io.Ci;
        sub_q[0] <= io.Sub;
        ls_q[0]  <= lane_segs(io.LaneMode);
      end
      for (int j = 1; j <= NSEG; j++) begin
        v_q[j]   <= v_q[j-1];
        a_q[j]   <= a_q[j-1];
        b_q[j]   <= b_q[j-1];
        s_q[j]   <= s_d[j];
        co_q[j]  <= co_d[j];
        cy_q[j]  <= cy_d[j];
        ci_q[j]  <= ci_q[j-1];
        sub_q[j] <= sub_q[j-1];
        ls_q[j]  <= ls_q[j-1];
      end
    end
  end
endmodule

// File: tb/tb_simd_pipelined_adder.sv
// tb_simd_pipelined_adder: directed + random scoreboard bench.
// Bit-serial lane model feeds a queue; a negedge monitor pops and compares.
module tb_simd_pipelined_adder;
  localparam int W    = 64;
  localparam int SEG  = 16;
  localparam int NSEG = W / SEG;

  typedef struct packed {
    logic [W-1:0]    s;
    logic [NSEG-1:0] co;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  simd_pipelined_adder_if #(.WIDTH(W), .SEG(SEG)) io();

  simd_pipelined_adder #(.WIDTH(W), .SEG(SEG)) dut (
    .Clk (clk),
    .Rst (rst),
    .io  (io)
  );

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   pops = 0;
  int   pop_first = 0;
  int   pop_last = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic ci,
                       input logic sub,
                       input logic [1:0] m,
                       output exp_t e);
    int   l;
    logic c;
    logic bb;
    l = (m == 2'd3) ? W : (SEG << m);
    if (l > W) l = W;
    e = '0;
    c = 1'b0;
    for (int n = 0; n < W; n++) begin
      if (n % l == 0) c = sub ? 1'b1 : ((n == 0) ? ci : 1'b0);
      bb = sub ? ~b[n] : b[n];
      e.s[n] = a[n] ^ bb ^ c;
      c = (a[n] & bb) | (a[n] & c) | (bb & c);
      if (n % l == l - 1) e.co[n / SEG] = c;
    end
  endtask

  task automatic send(input logic [W-1:0] a,
                      input logic [W-1:0] b,
                      input logic ci,
                      input logic sub,
                      input logic [1:0] m,
                      input exp_t e);
    logic ok;
    ok = 1'b0;
    io.A = a;
    io.B = b;
    io.Ci = ci;
    io.Sub = sub;
    io.LaneMode = m;
    io.InValid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (io.InReady === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept", 64'(ok), 64'd1);
    if (ok) q.push_back(e);
    @(posedge clk);
    #1;
    io.InValid = 1'b0;
  endtask

  task automatic send_m(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic ci,
                        input logic sub,
                        input logic [1:0] m);
    exp_t e;
    model(a, b, ci, sub, m, e);
    send(a, b, ci, sub, m, e);
  endtask

  task automatic drain();
    for (int t = 0; t < 80; t++) begin
      if (q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  task automatic wait_out();
    for (int t = 0; t < 20; t++) begin
      if (io.OutValid === 1'b1) break;
      @(posedge clk);
      #1;
    end
    chk("wait_out", 64'(io.OutValid), 64'd1);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && io.OutValid === 1'b1 &&
        io.OutReady === 1'b1) begin
      chk("mon_has_exp", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        chk("mon_s", io.S, mon_e.s);
        chk("mon_co", 64'(io.Co), 64'(mon_e.co));
      end
      if (pops == 0) pop_first = cyc;
      pop_last = cyc;
      pops++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ma;
    logic [W-1:0] mb;
    logic [W-1:0] ss;
    logic [NSEG-1:0] sc;
    logic stalled;
    io.A = '0;
    io.B = '0;
    io.Ci = 1'b0;
    io.Sub = 1'b0;
    io.LaneMode = 2'd0;
    io.InValid = 1'b0;
    io.OutReady = 1'b1;

    #12;
    chk("rst_valid", 64'(io.OutValid), 64'd0);
    chk("rst_s", io.S, 64'd0);
    chk("rst_co", 64'(io.Co), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_inready", 64'(io.InReady), 64'd1);

    // full-width carry, with latency check
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 2'd3,
         '{s: 64'd0, co: 4'b1000});
    repeat (3) @(posedge clk);
    #1;
    chk("lat_early", 64'(io.OutValid), 64'd0);
    @(posedge clk);
    #1;
    chk("lat_due", 64'(io.OutValid), 64'd1);

    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0001_0001_0001_0001,
         1'b0, 1'b0, 2'd0, '{s: 64'd0, co: 4'b1111});
    send(64'd0, 64'd0, 1'b1, 1'b0, 2'd0,
         '{s: 64'd1, co: 4'b0000});
    send(64'h0000_0003_0000_0005, 64'h0000_0005_0000_0003,
         1'b0, 1'b1, 2'd1,
         '{s: 64'hFFFF_FFFE_0000_0002, co: 4'b0010});
    drain();

    // mixed modes back-to-back, no bubbles expected
    pops = 0;
    ma = 64'hFFFF_8000_7FFF_0001;
    mb = 64'h0001_8000_0001_FFFF;
    for (int m = 0; m < 4; m++) send_m(ma, mb, 1'b1, 1'b0, 2'(m));
    for (int m = 0; m < 4; m++) send_m(ma, mb, 1'b1, 1'b1, 2'(m));
    drain();
    chk("mix_pops", 64'(pops), 64'd8);
    chk("mix_gap", 64'(pop_last - pop_first), 64'd7);

    // random operands with occasional input bubbles
    for (int r = 0; r < 16; r++) begin
      send_m({$urandom, $urandom}, {$urandom, $urandom},
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();

    // backpressure: stall 10 cycles at first output
    pops = 0;
    stalled = 1'b0;
    ss = '0;
    sc = '0;
    for (int i = 0; i < 8; i++) begin
      send_m({$urandom, $urandom}, {$urandom, $urandom},
             1'b1, 1'(i % 2), 2'(i % 4));
      if (!stalled && io.OutValid === 1'b1) begin
        stalled = 1'b1;
        io.OutReady = 1'b0;
        ss = io.S;
        sc = io.Co;
        for (int c = 0; c < 10; c++) begin
          io.A = {$urandom, $urandom};
          io.B = {$urandom, $urandom};
          io.InValid = 1'b1;
          @(posedge clk);
          #1;
          chk("bp_s", io.S, ss);
          chk("bp_co", 64'(io.Co), 64'(sc));
          chk("bp_valid", 64'(io.OutValid), 64'd1);
          chk("bp_inready", 64'(io.InReady), 64'd0);
        end
        io.InValid = 1'b0;
        io.OutReady = 1'b1;
      end
    end
    chk("bp_stalled", 64'(stalled), 64'd1);
    drain();
    chk("bp_pops", 64'(pops), 64'd8);
    chk("bp_gap", 64'(pop_last - pop_first), 64'd7);

    // reset with three transactions in flight
    io.OutReady = 1'b0;
    for (int i = 0; i < 3; i++)
      send_m({$urandom, $urandom} | 64'd1, 64'd0,
             1'b0, 1'b0, 2'd3);
    wait_out();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(io.OutValid), 64'd0);
    chk("mid_rst_s", io.S, 64'd0);
    chk("mid_rst_co", 64'(io.Co), 64'd0);
    chk("mid_rst_inready", 64'(io.InReady), 64'd1);
    q.delete();
    #2;
    rst = 1'b0;
    io.OutReady = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      chk("no_stale", 64'(io.OutValid), 64'd0);
    end
    send_m(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
           1'b0, 1'b0, 2'd2);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_early", 64'(io.OutValid), 64'd0);
    @(posedge clk);
    #1;
    chk("post_rst_due", 64'(io.OutValid), 64'd1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
